mem_access_unit: RTL
====================

# mem_access_unit

Memory-stage access unit of the pipelined CPU: takes the load/store issued by the EX/MEM register, runs a request/acknowledge transaction on the data-memory bus, and returns the sign/zero-extended load result as `mem_Datain` to the MEM/WB register. While the transaction is in flight it stalls the pipeline and suppresses the register write toward MEM/WB. It also handles sub-word alignment, byte strobes, misaligned-access detection and bus timeout.

## Interface
- `TIMEOUT`, 16: maximum cycles spent in WAIT before a bus error is flagged (legal range 1..65535).
- `clk  input  1`: clock, rising edge.
- `rst  input  1`: asynchronous active-low reset.
- `mem_MemRead  input  1`: load in MEM stage.
- `mem_MemWrite  input  1`: store in MEM stage; wins if both read and write are set.
- `mem_DMType  input  3`: access type.
  - 000 = word
  - 001 = half, signed
  - 010 = half, unsigned
  - 011 = byte, signed
  - 100 = byte, unsigned
  - Other codes are treated as word.
- `mem_aluout  input  32`: byte address.
- `mem_RD2  input  32`: store data, right-aligned.
- `mem_RegWrite  input  1`: RegWrite from EX/MEM.
- `out_RegWrite  output  1`: RegWrite to MEM/WB.
- `mem_Datain  output  32`: extended load data to MEM/WB.
- `mem_stall  output  1`: freeze PC, IF/ID, ID/EX and EX/MEM.
- `mem_misalign  output  1`: misaligned-access flag (combinational).
- `mem_buserr  output  1`: timeout flag, one cycle.
- `dm_req  output  1`: bus request.
- `dm_we  output  1`: write enable.
- `dm_addr  output  32`: word-aligned address, bits [1:0] = 00.
- `dm_wdata  output  32`: lane-replicated store data.
- `dm_wstrb  output  4`: byte strobes.
- `dm_ack  input  1`: bus acknowledge; sampled only in WAIT.
- `dm_rdata  input  32`: read data, valid with `dm_ack`.

## Operation
- **access** = (`mem_MemRead` | `mem_MemWrite`) & ~`mem_misalign`.
- **mem_misalign** is 1 when:
  - an access is a word and `mem_aluout[1:0]` != 0, or
  - an access is a half and `mem_aluout[0]` != 0.
  - A misaligned access issues no bus request, never stalls, forces `out_RegWrite` = 0, and drives `mem_Datain` = 0.
- **State machine** (IDLE, WAIT, DONE):
  - IDLE with access: `mem_stall` = 1. On the next edge, register `dm_addr`/`dm_we`/`dm_wdata`/`dm_wstrb`, set `dm_req` = 1, clear the timeout counter, and go to WAIT.
  - IDLE without access: no stall.
  - WAIT: `mem_stall` = 1 and `dm_req` is held with stable address, data and strobes. Each edge:
    - If `dm_ack` = 1: capture the extended `dm_rdata` (for loads) into the data register, drop `dm_req`, go to DONE.
    - Else if the counter = TIMEOUT-1: drop `dm_req`, set the data register to 0, pulse `mem_buserr` for the DONE cycle, go to DONE.
    - Else: increment the counter.
  - DONE: `mem_stall` = 0 and `mem_Datain` = data register. The pipeline advances on this edge, and the state returns to IDLE unconditionally, so the next instruction is evaluated fresh in IDLE.
- **out_RegWrite** = `mem_RegWrite` & ~`mem_stall` & ~`mem_misalign`. A stalled MEM/WB therefore captures a bubble.
- **mem_Datain** = data register in DONE, otherwise 0. Stores also leave 0.
- **Load extension** (k = `mem_aluout[1:0]`):
  - Byte: lane k, bits [8k+7:8k], then sign- or zero-extended.
  - Half: lane k/2, sign- or zero-extended.
  - Word: unchanged.
- **Store formatting**:
  - Byte: `dm_wdata` = `{4{RD2[7:0]}}`, `dm_wstrb` = 0001 << k.
  - Half: `dm_wdata` = `{2{RD2[15:0]}}`, `dm_wstrb` = 0011 << k.
  - Word: `dm_wdata` = RD2, `dm_wstrb` = 1111.
  - Loads: `dm_wstrb` = 0000.

## Timing
- **Reset values:**
  - 0: `dm_req`, `dm_we`, `dm_addr`, `dm_wdata`, `dm_wstrb`, `mem_Datain`, `mem_buserr`; the data register and the counter.
  - IDLE: state.
  - `mem_stall` = 0, `out_RegWrite` = 0 while reset is asserted.
- **Reset mid-transaction:** `dm_req` drops asynchronously, the transaction is abandoned, and no late ack is honoured.
- **Latency:** an access with `dm_ack` in the first WAIT cycle occupies MEM for 3 cycles (IDLE, WAIT, DONE) with 2 stall cycles. Each additional wait cycle adds one stall.
- **Timeout:** `mem_buserr` asserts exactly TIMEOUT cycles after `dm_req` rises, followed by DONE.
- **dm_ack outside WAIT** is ignored.
- **Back-to-back accesses:** every access passes through IDLE, so `dm_req` has at least one low cycle between transactions.
- **Non-memory instructions:** zero added latency.

## Test plan
- LW 0x100, ack on first WAIT cycle, rdata 0xDEADBEEF -> `mem_stall` high 2 cycles; `dm_req` for 1 cycle with `dm_addr` 0x100, `dm_wstrb` 0000; DONE `mem_Datain` 0xDEADBEEF; `out_RegWrite` = 1 only in DONE.
- LB at 0x103 and LBU at 0x103, rdata 0x80FF7F01 -> `mem_Datain` 0xFFFFFF80 and 0x00000080; LH at 0x102 -> 0xFFFF80FF.
- SB at 0x201, RD2 0x123456AB -> `dm_addr` 0x200, `dm_wdata` 0xABABABAB, `dm_wstrb` 0010, `dm_we` = 1; SH at 0x202 -> `dm_wstrb` 1100, `dm_wdata` 0x56AB56AB.
- LW at 0x102 -> `mem_misalign` = 1, `dm_req` stays 0, no stall, `out_RegWrite` = 0.
- TIMEOUT = 4, `dm_ack` held 0 -> `dm_req` high exactly 4 cycles, `mem_buserr` 1-cycle pulse in DONE, `mem_Datain` = 0, pipeline resumes.
- Ack delayed 3 cycles, `rst` pulled low during the second WAIT cycle -> `dm_req` 0 immediately; after release, state IDLE with all outputs 0; a subsequent ack is ignored.

Source files
------------

// File: rtl/mem_access_unit_if.sv
// Data-memory request/acknowledge bus between the MEM-stage access unit and the memory.
interface mem_access_unit_if;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        dm_ack;
    logic [31:0] dm_rdata;

    modport master (
        output dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        input  dm_ack, dm_rdata
    );

    modport slave (
        input  dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb,
        output dm_ack, dm_rdata
    );
endinterface

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: runs one req/ack bus transaction per access, formats stores, extends loads.
// Latency: 3 cycles (IDLE, WAIT, DONE) plus one per extra wait cycle; pipeline stalled until DONE.
module mem_access_unit #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  mem_MemRead,
    input  logic                  mem_MemWrite,
    input  logic [2:0]            mem_DMType,
    input  logic [31:0]           mem_aluout,
    input  logic [31:0]           mem_RD2,
    input  logic                  mem_RegWrite,
    output logic                  out_RegWrite,
    output logic [31:0]           mem_Datain,
    output logic                  mem_stall,
    output logic                  mem_misalign,
    output logic                  mem_buserr,
    mem_access_unit_if.master     dm
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  wstrb_q, wstrb_d;
    logic [31:0] data_q, data_d;
    logic [15:0] cnt_q, cnt_d;
    logic        buserr_q, buserr_d;
    logic [2:0]  ty_q, ty_d;
    logic [1:0]  off_q, off_d;
    logic        load_q, load_d;

    logic        is_byte, is_half, is_word, access;
    logic [31:0] wdata_fmt;
    logic [3:0]  wstrb_fmt;

    function automatic logic [31:0] load_ext(input logic [2:0] ty, input logic [1:0] k,
                                             input logic [31:0] rd);
        logic [7:0]  b;
        logic [15:0] h;
        b = rd[{k, 3'b000} +: 8];
        h = k[1] ? rd[31:16] : rd[15:0];
        case (ty)
            3'b001:  load_ext = {{16{h[15]}}, h};
            3'b010:  load_ext = {16'h0000, h};
            3'b011:  load_ext = {{24{b[7]}}, b};
            3'b100:  load_ext = {24'h000000, b};
            default: load_ext = rd;
        endcase
    endfunction

    assign is_byte = (mem_DMType == 3'b011) || (mem_DMType == 3'b100);
    assign is_half = (mem_DMType == 3'b001) || (mem_DMType == 3'b010);
    assign is_word = !is_byte && !is_half;

    assign mem_misalign = (mem_MemRead || mem_MemWrite) &&
                          ((is_word && (mem_aluout[1:0] != 2'b00)) ||
                           (is_half && mem_aluout[0]));
    assign access = (mem_MemRead || mem_MemWrite) && !mem_misalign;

    // Sub-word stores replicate the datum on every lane; strobes pick the addressed one.
    always_comb begin
        wdata_fmt = mem_RD2;
        wstrb_fmt = 4'b1111;
        if (is_byte) begin
            wdata_fmt = {4{mem_RD2[7:0]}};
            wstrb_fmt = 4'b0001 << mem_aluout[1:0];
        end else if (is_half) begin
            wdata_fmt = {2{mem_RD2[15:0]}};
            wstrb_fmt = 4'b0011 << mem_aluout[1:0];
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        we_d     = we_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        wstrb_d  = wstrb_q;
        data_d   = data_q;
        cnt_d    = cnt_q;
        buserr_d = 1'b0;
        ty_d     = ty_q;
        off_d    = off_q;
        load_d   = load_q;
        case (state_q)
            S_IDLE: begin
                if (access) begin
                    state_d = S_WAIT;
                    req_d   = 1'b1;
                    we_d    = mem_MemWrite;
                    addr_d  = {mem_aluout[31:2], 2'b00};
                    wdata_d = wdata_fmt;
                    wstrb_d = mem_MemWrite ? wstrb_fmt : 4'b0000;
                    cnt_d   = '0;
                    ty_d    = mem_DMType;
                    off_d   = mem_aluout[1:0];
                    load_d  = !mem_MemWrite;
                end
            end
            S_WAIT: begin
                // Ack takes priority over timeout when both land on the same edge.
                if (dm.dm_ack) begin
                    data_d  = load_q ? load_ext(ty_q, off_q, dm.dm_rdata) : '0;
                    req_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    data_d   = '0;
                    req_d    = 1'b0;
                    buserr_d = 1'b1;
                    state_d  = S_DONE;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            req_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            data_q   <= '0;
            cnt_q    <= '0;
            buserr_q <= 1'b0;
            ty_q     <= '0;
            off_q    <= '0;
            load_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            req_q    <= req_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            wstrb_q  <= wstrb_d;
            data_q   <= data_d;
            cnt_q    <= cnt_d;
            buserr_q <= buserr_d;
            ty_q     <= ty_d;
            off_q    <= off_d;
            load_q   <= load_d;
        end
    end

    assign mem_stall    = rst && (((state_q == S_IDLE) && access) || (state_q == S_WAIT));
    assign out_RegWrite = rst && mem_RegWrite && !mem_stall && !mem_misalign;
    assign mem_Datain   = (state_q == S_DONE) ? data_q : '0;
    assign mem_buserr   = buserr_q;

    assign dm.dm_req   = req_q;
    assign dm.dm_we    = we_q;
    assign dm.dm_addr  = addr_q;
    assign dm.dm_wdata = wdata_q;
    assign dm.dm_wstrb = wstrb_q;
endmodule
